// File: rtl/alu_pkg.sv
// Shared width default and 4-bit opcode encodings for the ALU and its adder.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SLL  = 4'b0010;
   localparam logic [3:0] OP_SLT  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1010;
   localparam logic [3:0] OP_XOR  = 4'b1100;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder a + (b ^ {sub}) + sub with carry out and signed overflow.
// Purely combinational; no flow control.
module alu_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full;

   assign b_eff  = b_i ^ {WIDTH{sub_i}};
   assign full   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
   assign sum_o  = full[WIDTH-1:0];
   assign cout_o = full[WIDTH];
   // Overflow: both addends carry the same sign but the sum does not.
   assign ovf_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, accepts a new operation every cycle, no backpressure.
// Result mux and flags are combinational; a single register stage drives every output.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       G,
   output logic [WIDTH-1:0] Result,
   output logic             C,
   output logic             V,
   output logic             Z
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             sub;
   logic [SHW-1:0]   shamt;

   logic [WIDTH-1:0] result_d, result_q;
   logic             c_d, c_q;
   logic             v_d, v_q;
   logic             z_d, z_q;

   // Compare opcodes reuse the subtractor so their flags match SUB exactly.
   assign sub   = (G == OP_SUB) || (G == OP_SLT) || (G == OP_SLTU);
   assign shamt = B[SHW-1:0];

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a_i    (A),
      .b_i    (B),
      .sub_i  (sub),
      .sum_o  (sum),
      .cout_o (cout),
      .ovf_o  (ovf)
   );

   always_comb begin
      result_d = '0;
      c_d      = 1'b0;
      v_d      = 1'b0;
      case (G)
         OP_ADD, OP_SUB: begin
            result_d = sum;
            c_d      = cout;
            v_d      = ovf;
         end
         OP_SLT: begin
            result_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            c_d      = cout;
            v_d      = ovf;
         end
         OP_SLTU: begin
            result_d = {{(WIDTH-1){1'b0}}, ~cout};
            c_d      = cout;
            v_d      = ovf;
         end
         OP_SLL:  result_d = A << shamt;
         OP_SRL:  result_d = A >> shamt;
         OP_SRA:  result_d = $signed(A) >>> shamt;
         OP_AND:  result_d = A & B;
         OP_OR:   result_d = A | B;
         OP_XOR:  result_d = A ^ B;
         default: result_d = '0;
      endcase
      z_d = (result_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b1;
      end else begin
         result_q <= result_d;
         c_q      <= c_d;
         v_q      <= v_d;
         z_q      <= z_d;
      end
   end

   assign Result = result_q;
   assign C      = c_q;
   assign V      = v_q;
   assign Z      = z_q;

endmodule

// File: tb/tb_alu.sv
// Randomized bench for alu: arithmetic reference model checked every cycle plus literal vectors.
module tb_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A, B;
   logic [3:0]  G;
   logic [31:0] Result;
   logic        C, V, Z;

   int checks = 0;
   int errors = 0;

   alu #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .G      (G),
      .Result (Result),
      .C      (C),
      .V      (V),
      .Z      (Z)
   );

   always #5 clk = ~clk;

   // Reference: {result, C, V, Z} from plain 64-bit arithmetic.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] g, input logic r);
      longint sa, sb, s;
      longint unsigned ua, ub;
      logic [31:0] res;
      logic        c, v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      res = 32'd0;
      c = 1'b0;
      v = 1'b0;
      if (r) return {32'd0, 1'b0, 1'b0, 1'b1};
      case (g)
         4'b0000: begin
            res = a + b;
            c = (ua + ub) > 64'hFFFF_FFFF;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'b0001, 4'b0011, 4'b0101: begin
            res = a - b;
            c = (ua >= ub);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            if (g == 4'b0011) res = (sa < sb) ? 32'd1 : 32'd0;
            if (g == 4'b0101) res = (ua < ub) ? 32'd1 : 32'd0;
         end
         4'b0010: res = a << b[4:0];
         4'b0100: res = a >> b[4:0];
         4'b0110: res = $signed(a) >>> b[4:0];
         4'b1000: res = a & b;
         4'b1010: res = a | b;
         4'b1100: res = a ^ b;
         default: res = 32'd0;
      endcase
      return {res, c, v, (res == 32'd0)};
   endfunction

   task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got Result=%h C=%b V=%b Z=%b, want Result=%h C=%b V=%b Z=%b",
                  nm, act[34:3], act[2], act[1], act[0], exp[34:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Per-cycle compare: expectation captured at each rising edge, DUT sampled on the falling edge.
   logic [34:0] exp_q;
   bit          mon_en = 0;

   always @(posedge clk) begin
      exp_q  = model(A, B, G, rst);
      mon_en = 1;
   end

   always @(negedge clk) begin
      if (mon_en) chk("cycle", {Result, C, V, Z}, exp_q);
   end

   // Literal vector: checks the DUT one edge after the inputs and pins the model to the same value.
   task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] g, input logic [31:0] er, input logic ec,
                      input logic ev, input logic ez, input logic r = 1'b0);
      @(negedge clk);
      rst = r; A = a; B = b; G = g;
      @(posedge clk);
      #1;
      chk({nm, "/dut"}, {Result, C, V, Z}, {er, ec, ev, ez});
      chk({nm, "/model"}, model(a, b, g, r), {er, ec, ev, ez});
   endtask

   initial begin
      logic [3:0]  ops [10];
      logic [31:0] corner [6];
      logic [31:0] ra, rb;
      logic [3:0]  rg;
      ops    = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SRL, OP_SLTU, OP_SRA, OP_AND, OP_OR, OP_XOR};
      corner = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1F};

      rst = 1'b1; A = 32'hDEAD_BEEF; B = 32'h1234_5678; G = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", {Result, C, V, Z}, {32'd0, 1'b0, 1'b0, 1'b1});

      lit("slt_0_0",   32'd0, 32'd0, OP_SLT,  32'd0, 1'b1, 1'b0, 1'b1);
      lit("sltu_0_0",  32'd0, 32'd0, OP_SLTU, 32'd0, 1'b1, 1'b0, 1'b1);

      lit("add_40_20",  32'd40, 32'd20, OP_ADD,  32'd60, 1'b0, 1'b0, 1'b0);
      lit("sub_40_20",  32'd40, 32'd20, OP_SUB,  32'd20, 1'b1, 1'b0, 1'b0);
      lit("slt_40_20",  32'd40, 32'd20, OP_SLT,  32'd0,  1'b1, 1'b0, 1'b1);
      lit("sltu_40_20", 32'd40, 32'd20, OP_SLTU, 32'd0,  1'b1, 1'b0, 1'b1);
      lit("and_40_20",  32'd40, 32'd20, OP_AND,  32'd0,  1'b0, 1'b0, 1'b1);
      lit("or_40_20",   32'd40, 32'd20, OP_OR,   32'd60, 1'b0, 1'b0, 1'b0);
      lit("xor_40_20",  32'd40, 32'd20, OP_XOR,  32'd60, 1'b0, 1'b0, 1'b0);

      lit("add_40_70",  32'd40, 32'd70, OP_ADD,  32'd110,       1'b0, 1'b0, 1'b0);
      lit("sub_40_70",  32'd40, 32'd70, OP_SUB,  32'hFFFF_FFE2, 1'b0, 1'b0, 1'b0);
      lit("slt_40_70",  32'd40, 32'd70, OP_SLT,  32'd1,         1'b0, 1'b0, 1'b0);
      lit("sltu_40_70", 32'd40, 32'd70, OP_SLTU, 32'd1,         1'b0, 1'b0, 1'b0);
      lit("and_40_70",  32'd40, 32'd70, OP_AND,  32'd0,         1'b0, 1'b0, 1'b1);
      lit("or_40_70",   32'd40, 32'd70, OP_OR,   32'd110,       1'b0, 1'b0, 1'b0);
      lit("xor_40_70",  32'd40, 32'd70, OP_XOR,  32'd110,       1'b0, 1'b0, 1'b0);

      lit("add_n40_n30",  32'hFFFF_FFD8, 32'hFFFF_FFE2, OP_ADD,  32'hFFFF_FFBA, 1'b1, 1'b0, 1'b0);
      lit("sub_n40_n30",  32'hFFFF_FFD8, 32'hFFFF_FFE2, OP_SUB,  32'hFFFF_FFF6, 1'b0, 1'b0, 1'b0);
      lit("slt_n40_n30",  32'hFFFF_FFD8, 32'hFFFF_FFE2, OP_SLT,  32'd1,         1'b0, 1'b0, 1'b0);
      lit("sltu_n40_n30", 32'hFFFF_FFD8, 32'hFFFF_FFE2, OP_SLTU, 32'd1,         1'b0, 1'b0, 1'b0);

      lit("add_ovf",  32'h7FFF_FFFF, 32'd1,  OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      lit("sub_ovf",  32'h8000_0000, 32'd1,  OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      lit("sra_31",   32'h8000_0000, 32'd31, OP_SRA, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      lit("srl_31",   32'h8000_0000, 32'd31, OP_SRL, 32'd1,         1'b0, 1'b0, 1'b0);
      lit("sll_b32",  32'h0000_1234, 32'd32, OP_SLL, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
      lit("sll_4",    32'h8000_0001, 32'h24, OP_SLL, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
      lit("illegal",  32'd5, 32'd5, 4'b1111, 32'd0, 1'b0, 1'b0, 1'b1);
      lit("rst_add",  32'd5, 32'd6, OP_ADD,  32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      lit("after_rst", 32'd5, 32'd6, OP_ADD, 32'd11, 1'b0, 1'b0, 1'b0);

      // Back-to-back random traffic; the per-cycle compare does the checking.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 4) == 0) rb = ra;
         rg = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)];
         rst = ($urandom_range(0, 40) == 0);
         A = ra; B = rb; G = rg;
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; all values below assume 32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: A  input  WIDTH  operand A (two's complement or unsigned per opcode).
REQ-005 Port: B  input  WIDTH  operand B; B[4:0] is the shift amount for shift opcodes.
REQ-006 Port: G  input  4  operation select.
REQ-007 Port: Result  output  WIDTH  registered operation result.
REQ-008 Port: C  output  1  registered carry flag.
REQ-009 Port: V  output  1  registered signed-overflow flag.
REQ-010 Port: Z  output  1  registered zero flag.

Function
REQ-011 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SRL, 0101 SLTU, 0110 SRA, 1000 AND, 1010 OR, 1100 XOR.
REQ-012 Unlisted G codes SHALL produce Result=0, C=0, V=0, Z=1.
REQ-013 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N; no handshake, a new operation is accepted every cycle.
REQ-014 ADD: Result=(A+B) mod 2^32; C=carry out of bit 31; V=1 when A, B share sign and Result sign differs.
REQ-015 SUB: Result=(A-B) mod 2^32, computed as A+~B+1; C=carry out of that sum (1 = no borrow, A>=B unsigned); V=1 when A, B signs differ and Result sign differs from A.
REQ-016 SLT: Result=1 if A<B signed else 0 (sign of A-B XOR overflow); C, V SHALL equal the SUB flags for the same operands.
REQ-017 SLTU: Result=1 if A<B unsigned else 0 (i.e. NOT SUB carry); C, V SHALL equal SUB flags.
REQ-018 SLL/SRL/SRA: shift A by B[4:0]; SRL zero-fills, SRA sign-fills; B[31:5] ignored; shift by 0 returns A; C=0, V=0.
REQ-019 AND/OR/XOR: bitwise on A, B; C=0, V=0.
REQ-020 Z SHALL be 1 exactly when the registered Result equals 0, for every opcode.
REQ-021 All outputs SHALL be driven from registers only; no combinational path from inputs to outputs.

Reset
REQ-022 When rst=1 at a rising edge: Result=0, C=0, V=0, Z=1 after that edge, regardless of A, B, G.
REQ-023 rst asserted mid-stream SHALL discard the operation sampled at that edge; the first valid result appears one cycle after the first edge with rst=0.

Structure
REQ-024 Package alu_pkg SHALL hold the WIDTH default and the 4-bit opcode constants of REQ-011.
REQ-025 One sub-module alu_addsub SHALL implement the shared A+(B^{sub})+sub adder producing sum, carry out and overflow, used by ADD/SUB/SLT/SLTU.
REQ-026 Result mux and flag logic combinational; one output register stage in alu.

Verification
REQ-027 A=0,B=0: SLT -> Result=0,Z=1; SLTU -> Result=0,Z=1,C=1.
REQ-028 A=40,B=20: ADD -> 60,C=0,V=0,Z=0; SUB -> 20,C=1; SLT -> 0; SLTU -> 0,Z=1; AND -> 0,Z=1; OR -> 60; XOR -> 60.
REQ-029 A=40,B=70: ADD -> 110; SUB -> 0xFFFFFFE2,C=0,V=0; SLT -> 1; SLTU -> 1; AND -> 0,Z=1; OR -> 110; XOR -> 110.
REQ-030 A=-40,B=-30: ADD -> 0xFFFFFFBA,C=1,V=0; SUB -> 0xFFFFFFF6,C=0,V=0; SLT -> 1; SLTU -> 1.
REQ-031 Boundaries: 0x7FFFFFFF ADD 1 -> 0x80000000,V=1,C=0; 0x80000000 SUB 1 -> 0x7FFFFFFF,V=1; 0x80000000 SRA 31 -> 0xFFFFFFFF; SRL 31 -> 1.
REQ-032 Timing/reset: output changes exactly one edge after input change; rst=1 during an ADD -> Result=0,Z=1,C=0,V=0 next cycle; G=1111 -> Result=0,Z=1.
